// File: rtl/hwpe_stream_deserialize.sv
// ----------------------------------------------------------------------------
// hwpe_stream_deserialize
//
// Splits one HWPE-Stream input into NB_OUT_STREAMS output streams in time.
// Packets go round-robin to the outputs, nb_contig_m1+1 contiguous packets per
// output before moving to the next one. This is the receive-side twin of the
// stream serializer: a serializer/deserializer pair driven by the same control
// values restores the original per-lane split.
//
// Optional feature macro: HWPE_STREAM_DESERIALIZE_OUT_REG_EN
//   defined   -> one-entry register per output (1-cycle latency; output valid
//                no longer depends combinationally on input valid)
//   undefined -> purely combinational datapath (0-cycle latency)
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   clear_i                  synchronous soft clear of all state
//   ctrl_clear_serdes_state  reload selection from ctrl_first_stream
//   ctrl_first_stream        first output after a serdes-state clear
//   ctrl_nb_contig_m1        contiguous packets per output minus one (live)
//   push_valid/ready/data/strb   input stream (sink)
//   pop_valid/ready/data/strb    output streams (source), one lane per output
// ----------------------------------------------------------------------------
module hwpe_stream_deserialize #(
  parameter int unsigned NB_OUT_STREAMS = 2,
  parameter int unsigned CONTIG_LIMIT   = 1024,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         clear_i,

  input  logic                                         ctrl_clear_serdes_state,
  input  logic [9:0]                                   ctrl_first_stream,
  input  logic [$clog2(CONTIG_LIMIT)-1:0]              ctrl_nb_contig_m1,

  input  logic                                         push_valid,
  output logic                                         push_ready,
  input  logic [DATA_WIDTH-1:0]                        push_data,
  input  logic [DATA_WIDTH/8-1:0]                      push_strb,

  output logic [NB_OUT_STREAMS-1:0]                    pop_valid,
  input  logic [NB_OUT_STREAMS-1:0]                    pop_ready,
  output logic [NB_OUT_STREAMS-1:0][DATA_WIDTH-1:0]    pop_data,
  output logic [NB_OUT_STREAMS-1:0][DATA_WIDTH/8-1:0]  pop_strb
);

  localparam int unsigned SW = $clog2(NB_OUT_STREAMS);
  localparam int unsigned CW = $clog2(CONTIG_LIMIT);

  logic [SW-1:0] stream_cnt_q, stream_cnt_d;
  logic [CW-1:0] contig_cnt_q, contig_cnt_d;
  logic          push_hs;
  logic          first_ok;

  assign push_hs  = push_valid & push_ready;
  // An out-of-range first_stream falls back to output 0.
  assign first_ok = ({22'd0, ctrl_first_stream} < NB_OUT_STREAMS);

  // A serdes-state clear wins over a same-cycle handshake: the packet still
  // goes to the old selection (datapath uses the _q values), but its counter
  // advance is dropped.
  always_comb begin
    stream_cnt_d = stream_cnt_q;
    contig_cnt_d = contig_cnt_q;
    if (ctrl_clear_serdes_state) begin
      stream_cnt_d = first_ok ? ctrl_first_stream[SW-1:0] : '0;
      contig_cnt_d = '0;
    end else if (push_hs) begin
      // nb_contig_m1 is compared live, so lowering it mid-burst ends the
      // burst on the next handshake.
      if (contig_cnt_q < ctrl_nb_contig_m1) begin
        contig_cnt_d = contig_cnt_q + CW'(1);
      end else begin
        contig_cnt_d = '0;
        stream_cnt_d = (stream_cnt_q == SW'(NB_OUT_STREAMS-1)) ? '0
                                                                : stream_cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      stream_cnt_q <= '0;
      contig_cnt_q <= '0;
    end else begin
      stream_cnt_q <= stream_cnt_d;
      contig_cnt_q <= contig_cnt_d;
    end
  end

`ifdef HWPE_STREAM_DESERIALIZE_OUT_REG_EN

  logic [NB_OUT_STREAMS-1:0]                   valid_q;
  logic [NB_OUT_STREAMS-1:0][DATA_WIDTH-1:0]   data_q;
  logic [NB_OUT_STREAMS-1:0][DATA_WIDTH/8-1:0] strb_q;

  // Load has priority over drain so a back-to-back refill keeps valid high.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < NB_OUT_STREAMS; i++) begin
        if (push_hs && (stream_cnt_q == SW'(i))) begin
          valid_q[i] <= 1'b1;
        end else if (pop_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Payload needs no reset; it is only observed while valid_q is set.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NB_OUT_STREAMS; i++) begin
      if (push_hs && (stream_cnt_q == SW'(i))) begin
        data_q[i] <= push_data;
        strb_q[i] <= push_strb;
      end
    end
  end

  assign push_ready = ~valid_q[stream_cnt_q] | pop_ready[stream_cnt_q];
  assign pop_valid  = valid_q;
  assign pop_data   = data_q;
  assign pop_strb   = strb_q;

`else

  assign push_ready = pop_ready[stream_cnt_q];

  always_comb begin
    pop_valid = '0;
    pop_data  = '0;
    pop_strb  = '0;
    for (int i = 0; i < NB_OUT_STREAMS; i++) begin
      pop_valid[i] = push_valid & (stream_cnt_q == SW'(i));
      pop_data[i]  = push_data;
      pop_strb[i]  = push_strb;
    end
  end

`endif

endmodule
